mul_r16_seq_ctrl: RTL and testbench

Sequential controller for the radix-16 Booth multiplier datapath. It accepts one unsigned WIDTH x WIDTH operand pair over a valid/ready handshake and precomputes the hard multiples 3A, 5A and 7A. It then retires one Booth digit per cycle into a product accumulator and presents the 2*WIDTH-bit product over a valid/ready handshake. It sits between the FPU mantissa path (FpuMultiplier=1) and downstream normalisation.

---
 rtl/mul_pkg.sv | 34 +++
 rtl/booth_r16_digit_enc.sv | 27 ++
 rtl/mul_r16_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_mul_r16_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the radix-16 Booth multiplier family: Booth digit selects,
// controller states and the digit-count derivation.
package mul_pkg;

   localparam int WIDTH         = 52;
   localparam int FpuMultiplier = 1;

   typedef enum logic [3:0] {
      PP_0  = 4'd0,
      PP_A  = 4'd1,
      PP_2A = 4'd2,
      PP_3A = 4'd3,
      PP_4A = 4'd4,
      PP_5A = 4'd5,
      PP_6A = 4'd6,
      PP_7A = 4'd7,
      PP_8A = 4'd8
   } booth_sel_t;

   typedef enum logic [1:0] {
      IDLE,
      PRECOMP,
      ITER,
      DONE
   } mul_ctrl_state_t;

   // One extra digit beyond WIDTH/4 keeps the top digit non-negative for unsigned operands.
   function automatic int ndig(input int w);
      return (w + 4) / 4;
   endfunction

   localparam int NDIG = ndig(WIDTH);

endpackage

// File: rtl/booth_r16_digit_enc.sv
// Radix-16 Booth digit encoder: a 5-bit multiplier window {b[4k+3:4k], b[4k-1]} becomes
// a magnitude select (0..8 multiples of A) and a sign.
module booth_r16_digit_enc
   import mul_pkg::*;
(
   input  logic [4:0] window,
   output booth_sel_t sel,
   output logic       neg
);

   logic [3:0] pos;
   logic [3:0] mag;

   // The top window bit weighs -8; a window of 1_1111 folds back to zero, not "negative zero".
   always_comb begin
      pos = {1'b0, window[3], 2'b00} + {2'b00, window[2], 1'b0}
          + {3'b000, window[1]} + {3'b000, window[0]};
      mag = pos;
      neg = 1'b0;
      if (window[4]) begin
         mag = 4'd8 - pos;
         neg = (pos != 4'd8);
      end
      sel = booth_sel_t'(mag);
   end

endmodule

// File: rtl/mul_r16_seq_ctrl.sv
// Sequential radix-16 Booth multiplier controller: accepts an unsigned operand pair,
// retires one Booth digit per cycle into an accumulator and presents the full product.
module mul_r16_seq_ctrl
   import mul_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [WIDTH-1:0]            a_i,
   input  logic [WIDTH-1:0]            b_i,
   input  logic                        flush_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [2*WIDTH-1:0]          prod_o,
   output logic                        busy_o,
   output logic [3:0]                  digit_sel_o,
   output logic                        digit_neg_o,
   output logic [$clog2(NDIG)-1:0]     digit_idx_o
);

   localparam int BEXT = 4*NDIG + 1;
   localparam int MW   = WIDTH + 3;
   localparam int PW   = 2*WIDTH;
   localparam int IW   = $clog2(NDIG);
   localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

   mul_ctrl_state_t state, state_next;

   logic [WIDTH-1:0] a_reg;
   logic [BEXT-1:0]  b_reg;
   logic [MW-1:0]    a_ext;
   logic [MW-1:0]    m3, m5, m7;
   logic [MW-1:0]    pp;
   logic [PW-1:0]    pp_shift;
   logic [PW-1:0]    acc, acc_next;
   logic [PW-1:0]    prod;
   logic [IW-1:0]    idx;
   logic [4:0]       window;
   booth_sel_t       enc_sel;
   logic             enc_neg;
   logic             accept;

   assign a_ext  = {3'b000, a_reg};
   assign window = 5'(b_reg >> {idx, 2'b00});

   booth_r16_digit_enc u_enc (
      .window (window),
      .sel    (enc_sel),
      .neg    (enc_neg)
   );

   always_comb begin
      pp = '0;
      case (enc_sel)
         PP_0:    pp = '0;
         PP_A:    pp = a_ext;
         PP_2A:   pp = a_ext << 1;
         PP_3A:   pp = m3;
         PP_4A:   pp = a_ext << 2;
         PP_5A:   pp = m5;
         PP_6A:   pp = m3 << 1;
         PP_7A:   pp = m7;
         PP_8A:   pp = a_ext << 3;
         default: pp = '0;
      endcase
   end

   // Wrap-around in the accumulator is harmless: the final sum always fits in PW bits.
   assign pp_shift = PW'(pp) << {idx, 2'b00};
   assign acc_next = enc_neg ? (acc - pp_shift) : (acc + pp_shift);

   // Flush outranks both handshakes; in IDLE it simply blocks the accept.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (!flush_i && in_valid_i) begin
               accept     = 1'b1;
               state_next = PRECOMP;
            end
         end
         PRECOMP: state_next = flush_i ? IDLE : ITER;
         ITER: begin
            if (flush_i)
               state_next = IDLE;
            else if (idx == LAST_IDX)
               state_next = DONE;
         end
         DONE: begin
            if (flush_i)
               state_next = IDLE;
            else if (out_ready_i) begin
               if (in_valid_i) begin
                  accept     = 1'b1;
                  state_next = PRECOMP;
               end else
                  state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         m3    <= '0;
         m5    <= '0;
         m7    <= '0;
         acc   <= '0;
         prod  <= '0;
         idx   <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            a_reg <= a_i;
            b_reg <= {{(BEXT-WIDTH-1){1'b0}}, b_i, 1'b0};
            acc   <= '0;
         end
         if (state == PRECOMP) begin
            m3  <= a_ext + (a_ext << 1);
            m5  <= a_ext + (a_ext << 2);
            m7  <= (a_ext << 3) - a_ext;
            idx <= '0;
         end
         if (state == ITER && !flush_i) begin
            acc <= acc_next;
            idx <= idx + 1'b1;
            if (idx == LAST_IDX)
               prod <= acc_next;
         end
         if (state_next == IDLE)
            idx <= '0;
      end
   end

   assign in_ready_o  = (state == IDLE) || (state == DONE && out_ready_i);
   assign out_valid_o = (state == DONE);
   assign busy_o      = (state != IDLE);
   assign prod_o      = prod;
   assign digit_idx_o = idx;
   assign digit_sel_o = (state == ITER) ? 4'(enc_sel) : 4'(PP_0);
   assign digit_neg_o = (state == ITER) && enc_neg;

endmodule

// File: tb/tb_mul_r16_seq_ctrl.sv
// Self-checking bench for mul_r16_seq_ctrl: directed scenarios plus a scoreboard of
// reference products popped on every output handshake.
module tb_mul_r16_seq_ctrl;
   import mul_pkg::*;

   localparam int PW = 2*WIDTH;
   localparam int IW = $clog2(NDIG);

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [PW-1:0]    prod;
   logic             busy;
   logic [3:0]       digit_sel;
   logic             digit_neg;
   logic [IW-1:0]    digit_idx;

   logic [PW-1:0]    sb[$];
   int               checks = 0;
   int               errors = 0;

   mul_r16_seq_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .flush_i     (flush),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .prod_o      (prod),
      .busy_o      (busy),
      .digit_sel_o (digit_sel),
      .digit_neg_o (digit_neg),
      .digit_idx_o (digit_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [PW-1:0] refMul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      return PW'(x) * PW'(y);
   endfunction

   // Scoreboard: inputs are stable at the falling edge, so handshakes are judged there.
   always @(negedge clk) begin
      if (rst || flush)
         sb.delete();
      else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0)
               checkOutput("spurious_valid", 1, 0);
            else
               checkOutput("product", prod, sb.pop_front());
         end
         if (in_valid && in_ready)
            sb.push_back(refMul(a, b));
      end
   end

   task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      int guard;
      guard    = 0;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready)
         checkOutput("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Cycles are counted with the accept cycle as number one.
   task automatic waitDone(output int cycles);
      cycles = 1;
      while (!out_valid && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      if (!out_valid)
         checkOutput("done_timeout", 0, 1);
   endtask

   task automatic runOp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      int cyc;
      applyStimulus(x, y);
      waitDone(cyc);
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_in_ready"},  in_ready,  1);
      checkOutput({tag, "_out_valid"}, out_valid, 0);
      checkOutput({tag, "_prod"},      prod,      0);
      checkOutput({tag, "_busy"},      busy,      0);
      checkOutput({tag, "_digit_sel"}, digit_sel, 0);
      checkOutput({tag, "_digit_neg"}, digit_neg, 0);
      checkOutput({tag, "_digit_idx"}, digit_idx, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int               cyc;
      int               stray;
      logic [63:0]      r;
      logic [WIDTH-1:0] ra, rb;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkResetValues("reset");
      rst = 1'b0;

      $display("[TB] basic latency 3*5");
      applyStimulus(52'd3, 52'd5);
      checkOutput("busy_after_accept", busy, 1);
      waitDone(cyc);
      checkOutput("latency", cyc, NDIG + 2);
      @(posedge clk);
      #1;

      $display("[TB] extreme operands");
      runOp({WIDTH{1'b1}}, {WIDTH{1'b1}});
      runOp(52'd0, 52'hF_1234_5678_9ABC);
      runOp(52'h8_7654_3210_FEDC, 52'd0);

      $display("[TB] negative-eight digit 7*8");
      applyStimulus(52'd7, 52'd8);
      @(posedge clk);
      #1;
      checkOutput("k0_sel", digit_sel, 8);
      checkOutput("k0_neg", digit_neg, 1);
      checkOutput("k0_idx", digit_idx, 0);
      @(posedge clk);
      #1;
      checkOutput("k1_sel", digit_sel, 1);
      checkOutput("k1_neg", digit_neg, 0);
      checkOutput("k1_idx", digit_idx, 1);
      waitDone(cyc);
      @(posedge clk);
      #1;

      $display("[TB] back-pressure then back-to-back");
      out_ready = 1'b0;
      applyStimulus(52'd100, 52'd200);
      waitDone(cyc);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_prod", prod, 20000);
         checkOutput("bp_in_ready", in_ready, 0);
         checkOutput("bp_out_valid", out_valid, 1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = 52'd2;
      b         = 52'd9;
      #1;
      checkOutput("b2b_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("b2b_out_valid", out_valid, 0);
      checkOutput("b2b_busy", busy, 1);
      waitDone(cyc);
      @(posedge clk);
      #1;

      $display("[TB] flush in ITER k=6");
      applyStimulus(52'd123, 52'd456);
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      checkOutput("flush_at_idx", digit_idx, 6);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush_busy", busy, 0);
      checkOutput("flush_in_ready", in_ready, 1);
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid)
            stray++;
         @(posedge clk);
         #1;
      end
      checkOutput("flush_no_valid", stray, 0);
      runOp(52'd11, 52'd13);

      $display("[TB] reset mid-operation");
      applyStimulus(52'd999, 52'd777);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkResetValues("midreset");
      rst = 1'b0;
      runOp(52'd5, 52'd6);

      $display("[TB] random back-to-back operands");
      for (int i = 0; i < 1500; i++) begin
         r  = {$urandom(), $urandom()};
         ra = r[WIDTH-1:0];
         r  = {$urandom(), $urandom()};
         rb = r[WIDTH-1:0];
         case (i % 10)
            0: ra = {WIDTH{1'b1}};
            1: rb = {WIDTH{1'b1}};
            2: rb = {(WIDTH/4){4'h8}};
            3: ra = '0;
            default: ;
         endcase
         applyStimulus(ra, rb);
      end
      waitDone(cyc);
      @(posedge clk);
      #1;
      checkOutput("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
